// File: rtl/prep_ok_quorum_ctrl_if.sv
// PrepareOK metadata channel (backups -> leader) and commit-number state write
// channel (leader -> VR state block), bundled for the quorum controller.
interface prep_ok_quorum_ctrl_if #(
  parameter int OP_W   = 64,
  parameter int VIEW_W = 32,
  parameter int IDX_W  = 3
);
  logic              prep_ok_msg_val;
  logic              prep_ok_msg_rdy;
  logic [VIEW_W-1:0] prep_ok_view;
  logic [OP_W-1:0]   prep_ok_op_num;
  logic [IDX_W-1:0]  prep_ok_replica_idx;

  logic              commit_wr_req;
  logic [OP_W-1:0]   commit_wr_num;
  logic              commit_wr_rdy;

  // Environment side: feeds messages, accepts commit writes.
  modport master (
    output prep_ok_msg_val, prep_ok_view, prep_ok_op_num, prep_ok_replica_idx,
    input  prep_ok_msg_rdy,
    input  commit_wr_req, commit_wr_num,
    output commit_wr_rdy
  );

  // Controller side.
  modport slave (
    input  prep_ok_msg_val, prep_ok_view, prep_ok_op_num, prep_ok_replica_idx,
    output prep_ok_msg_rdy,
    output commit_wr_req, commit_wr_num,
    input  commit_wr_rdy
  );
endinterface

// File: rtl/prep_ok_quorum_ctrl.sv
// Leader-side PrepareOK quorum tracker: records backup acks per op in a
// sliding window, advances the commit number on quorum and issues one
// commit-number state write per scan pass.
module prep_ok_quorum_ctrl #(
  parameter int NUM_REPLICAS = 3,
  parameter int QUORUM       = NUM_REPLICAS / 2 + 1,
  parameter int OP_W         = 64,
  parameter int VIEW_W       = 32,
  parameter int IDX_W        = 3,
  parameter int WIN_LOG2     = 4
) (
  input  logic              clk,
  input  logic              rst,
  prep_ok_quorum_ctrl_if.slave bus,
  input  logic [VIEW_W-1:0] cur_view,
  input  logic [IDX_W-1:0]  my_replica_idx,
  input  logic [OP_W-1:0]   last_prepared_op,
  input  logic              commit_load_val,
  input  logic [OP_W-1:0]   commit_load_num,
  output logic [OP_W-1:0]   commit_num,
  output logic [15:0]       drop_cnt,
  output logic              engine_rdy
);

  localparam int              WIN       = 1 << WIN_LOG2;
  localparam logic [IDX_W:0]  NUM_REP_L = (IDX_W+1)'(NUM_REPLICAS);
  localparam logic [OP_W:0]   WIN_L     = (OP_W+1)'(WIN);

  typedef enum logic [1:0] {ST_READY, ST_RECORD, ST_SCAN, ST_WRITE_COMMIT} state_t;

  state_t state, state_nxt;

  logic [VIEW_W-1:0]       lat_view;
  logic [OP_W-1:0]         lat_op;
  logic [IDX_W-1:0]        lat_idx;
  logic [NUM_REPLICAS-1:0] ack_map [WIN];
  logic                    advanced;
  logic [OP_W-1:0]         wr_num;

  logic                    msg_rdy, do_drop, do_record, do_advance, to_write;

  function automatic int popcount(input logic [NUM_REPLICAS-1:0] v);
    int c = 0;
    for (int i = 0; i < NUM_REPLICAS; i++) c += int'(v[i]);
    return c;
  endfunction

  // Message classification and head-of-window check.
  logic [WIN_LOG2-1:0]     lat_slot, head_slot;
  logic [OP_W-1:0]         head_op;
  logic [NUM_REPLICAS-1:0] idx_onehot;
  logic                    bad_src, stale, bad_range, head_ok;

  assign lat_slot   = lat_op[WIN_LOG2-1:0];
  assign head_op    = commit_num + OP_W'(1);
  assign head_slot  = head_op[WIN_LOG2-1:0];
  assign idx_onehot = (NUM_REPLICAS)'(1) << lat_idx;
  assign bad_src    = (lat_view != cur_view) || ({1'b0, lat_idx} >= NUM_REP_L) ||
                      (lat_idx == my_replica_idx);
  assign stale      = (lat_op <= commit_num);
  assign bad_range  = (lat_op > last_prepared_op) ||
                      ({1'b0, lat_op} > ({1'b0, commit_num} + WIN_L));
  // The leader's own ack is implicit; a head at all-ones would wrap, so stop there.
  assign head_ok    = (commit_num != '1) && (head_op <= last_prepared_op) &&
                      (popcount(ack_map[head_slot]) + 1 >= QUORUM);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_READY;
    else     state <= state_nxt;
  end

  // Next-state and control strobes; a commit load overrides everything.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    msg_rdy    = 1'b0;
    do_drop    = 1'b0;
    do_record  = 1'b0;
    do_advance = 1'b0;
    to_write   = 1'b0;
    case (state)
      ST_READY: begin
        msg_rdy = !commit_load_val;
        if (bus.prep_ok_msg_val && !commit_load_val) state_nxt = ST_RECORD;
      end
      ST_RECORD: begin
        state_nxt = ST_READY;
        if (bad_src)        do_drop = 1'b1;
        else if (stale)     do_drop = 1'b0;
        else if (bad_range) do_drop = 1'b1;
        else begin
          do_record = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (head_ok) do_advance = 1'b1;
        else if (advanced) begin
          to_write  = 1'b1;
          state_nxt = ST_WRITE_COMMIT;
        end else state_nxt = ST_READY;
      end
      ST_WRITE_COMMIT: begin
        if (bus.commit_wr_rdy) state_nxt = ST_READY;
      end
      default: state_nxt = ST_READY;
    endcase
    if (commit_load_val) state_nxt = ST_READY;
  end

  // Message latch, ack window, commit number, drop counter and write value.
  // NOTE: the ack window is reset and cleared as a whole because a leftover
  // bit would count toward a later op's quorum once its slot is reused.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_num <= '0;
      drop_cnt   <= '0;
      wr_num     <= '0;
      advanced   <= 1'b0;
      lat_view   <= '0;
      lat_op     <= '0;
      lat_idx    <= '0;
      for (int i = 0; i < WIN; i++) ack_map[i] <= '0;
    end else if (commit_load_val) begin
      commit_num <= commit_load_num;
      advanced   <= 1'b0;
      for (int i = 0; i < WIN; i++) ack_map[i] <= '0;
    end else begin
      if (msg_rdy && bus.prep_ok_msg_val) begin
        lat_view <= bus.prep_ok_view;
        lat_op   <= bus.prep_ok_op_num;
        lat_idx  <= bus.prep_ok_replica_idx;
      end
      if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (do_record) begin
        ack_map[lat_slot] <= ack_map[lat_slot] | idx_onehot;
        advanced          <= 1'b0;
      end
      if (do_advance) begin
        ack_map[head_slot] <= '0;
        commit_num         <= head_op;
        advanced           <= 1'b1;
      end
      if (to_write) wr_num <= commit_num;
    end
  end

  assign bus.prep_ok_msg_rdy = msg_rdy;
  assign bus.commit_wr_req   = (state == ST_WRITE_COMMIT);
  assign bus.commit_wr_num   = wr_num;
  assign engine_rdy          = (state == ST_READY);

endmodule

// File: tb/tb_prep_ok_quorum_ctrl.sv
// Directed bench: a 3-replica and a 5-replica controller share the environment
// inputs; messages are steered to one of them at a time.
module tb_prep_ok_quorum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cur_view = 32'd5, m_view = '0;
  logic [63:0] m_op = '0, lpo = 64'd1, load_num = '0;
  logic [2:0]  m_idx = '0, my_idx = 3'd0;
  logic        val3 = 1'b0, val5 = 1'b0, load_val = 1'b0, wr_rdy = 1'b0;

  logic [63:0] commit3, commit5;
  logic [15:0] drop3, drop5;
  logic        eng3, eng5;

  int          n_checks = 0, n_fail = 0;
  int          writes3 = 0, writes5 = 0;
  logic [63:0] last_wr3 = '0;

  always #5 clk = ~clk;

  prep_ok_quorum_ctrl_if #(.OP_W(64), .VIEW_W(32), .IDX_W(3)) if3 ();
  prep_ok_quorum_ctrl_if #(.OP_W(64), .VIEW_W(32), .IDX_W(3)) if5 ();

  assign if3.prep_ok_msg_val     = val3;
  assign if3.prep_ok_view        = m_view;
  assign if3.prep_ok_op_num      = m_op;
  assign if3.prep_ok_replica_idx = m_idx;
  assign if3.commit_wr_rdy       = wr_rdy;
  assign if5.prep_ok_msg_val     = val5;
  assign if5.prep_ok_view        = m_view;
  assign if5.prep_ok_op_num      = m_op;
  assign if5.prep_ok_replica_idx = m_idx;
  assign if5.commit_wr_rdy       = wr_rdy;

  prep_ok_quorum_ctrl #(.NUM_REPLICAS(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .cur_view(cur_view),
    .my_replica_idx(my_idx), .last_prepared_op(lpo),
    .commit_load_val(load_val), .commit_load_num(load_num),
    .commit_num(commit3), .drop_cnt(drop3), .engine_rdy(eng3)
  );

  prep_ok_quorum_ctrl #(.NUM_REPLICAS(5)) dut5 (
    .clk(clk), .rst(rst), .bus(if5.slave), .cur_view(cur_view),
    .my_replica_idx(my_idx), .last_prepared_op(lpo),
    .commit_load_val(load_val), .commit_load_num(load_num),
    .commit_num(commit5), .drop_cnt(drop5), .engine_rdy(eng5)
  );

  // Count completed commit writes on each controller.
  always @(posedge clk) begin
    if (!rst && if3.commit_wr_req && wr_rdy) begin
      writes3++;
      last_wr3 = if3.commit_wr_num;
    end
    if (!rst && if5.commit_wr_req && wr_rdy) writes5++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one message to the selected controller and wait for its accept.
  task automatic send(input bit to5, input logic [31:0] v, input logic [63:0] op,
                      input logic [2:0] idx);
    int n = 0;
    @(negedge clk);
    m_view = v; m_op = op; m_idx = idx;
    if (to5) val5 = 1'b1; else val3 = 1'b1;
    #1;
    while (!(to5 ? if5.prep_ok_msg_rdy : if3.prep_ok_msg_rdy) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("send_accept", 64'(n < 50), 64'd1);
    @(negedge clk);
    val3 = 1'b0; val5 = 1'b0;
  endtask

  task automatic wait_idle(input bit to5, input string tag);
    int n = 0;
    #1;
    while (!(to5 ? eng5 : eng3) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  task automatic wait_req3(input string tag);
    int n = 0;
    #1;
    while (!if3.commit_wr_req && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  task automatic load(input logic [63:0] num);
    @(negedge clk);
    load_val = 1'b1; load_num = num;
    @(negedge clk);
    load_val = 1'b0;
    #1;
  endtask

  initial begin
    int w3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_commit3", commit3, 64'd0);
    check("rst_commit5", commit5, 64'd0);
    check("rst_drop3", 64'(drop3), 64'd0);
    check("rst_wr_req3", 64'(if3.commit_wr_req), 64'd0);
    check("rst_wr_num3", if3.commit_wr_num, 64'd0);
    check("rst_msg_rdy3", 64'(if3.prep_ok_msg_rdy), 64'd1);
    check("rst_eng3", 64'(eng3), 64'd1);

    // Single ack reaches quorum of 2; write held while rdy stays low.
    send(1'b0, 32'd5, 64'd1, 3'd1);
    wait_req3("t1_req_seen");
    check("t1_commit", commit3, 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("hold_req", 64'(if3.commit_wr_req), 64'd1);
      check("hold_num", if3.commit_wr_num, 64'd1);
      check("hold_msg_rdy", 64'(if3.prep_ok_msg_rdy), 64'd0);
      @(negedge clk); #1;
    end
    wr_rdy = 1'b1;
    @(negedge clk); #1;
    check("t1_ready_after_rdy", 64'(eng3), 64'd1);
    check("t1_req_dropped", 64'(if3.commit_wr_req), 64'd0);
    check("t1_writes", 64'(writes3), 64'd1);

    // Out-of-order acks: ops 3 and 2 wait, op 1 releases three ops in one write.
    load(64'd0);
    check("t2_loaded", commit3, 64'd0);
    lpo = 64'd3;
    w3 = writes3;
    send(1'b0, 32'd5, 64'd3, 3'd2); wait_idle(1'b0, "t2_idle_a");
    check("t2_op3_commit", commit3, 64'd0);
    send(1'b0, 32'd5, 64'd2, 3'd2); wait_idle(1'b0, "t2_idle_b");
    check("t2_op2_commit", commit3, 64'd0);
    check("t2_no_write", 64'(writes3), 64'(w3));
    send(1'b0, 32'd5, 64'd1, 3'd2); wait_idle(1'b0, "t2_idle_c");
    check("t2_commit", commit3, 64'd3);
    check("t2_one_write", 64'(writes3), 64'(w3 + 1));
    check("t2_write_num", last_wr3, 64'd3);

    // Rejects: view, self index, out-of-range index, window, beyond prepared.
    lpo = 64'd30;
    send(1'b0, 32'd6, 64'd4, 3'd1);  wait_idle(1'b0, "t3_idle_view");
    send(1'b0, 32'd5, 64'd4, 3'd0);  wait_idle(1'b0, "t3_idle_self");
    send(1'b0, 32'd5, 64'd4, 3'd3);  wait_idle(1'b0, "t3_idle_idx");
    send(1'b0, 32'd5, 64'd20, 3'd1); wait_idle(1'b0, "t3_idle_win");
    lpo = 64'd10;
    send(1'b0, 32'd5, 64'd11, 3'd1); wait_idle(1'b0, "t3_idle_lpo");
    check("t3_drop", 64'(drop3), 64'd5);
    check("t3_commit", commit3, 64'd3);
    send(1'b0, 32'd5, 64'd3, 3'd1);  wait_idle(1'b0, "t3_idle_stale");
    check("t3_stale_drop", 64'(drop3), 64'd5);
    send(1'b0, 32'd5, 64'd4, 3'd1);  wait_idle(1'b0, "t3_idle_ok");
    check("t3_commit_after", commit3, 64'd4);
    check("t3_write_num", last_wr3, 64'd4);

    // Five replicas: duplicate ack is idempotent, a second backup commits.
    send(1'b1, 32'd5, 64'd1, 3'd1); wait_idle(1'b1, "t4_idle_a");
    send(1'b1, 32'd5, 64'd1, 3'd1); wait_idle(1'b1, "t4_idle_b");
    check("t4_dup_no_commit", commit5, 64'd0);
    send(1'b1, 32'd5, 64'd1, 3'd3); wait_idle(1'b1, "t4_idle_c");
    check("t4_commit", commit5, 64'd1);
    check("t4_writes", 64'(writes5), 64'd1);

    // Leave a lone ack in slot 5 of the 5-replica window before the load.
    send(1'b1, 32'd5, 64'd5, 3'd2); wait_idle(1'b1, "t6_idle_pre");
    check("t6_pre_commit5", commit5, 64'd1);

    // Load during a pending write.
    wr_rdy = 1'b0;
    w3 = writes3;
    send(1'b0, 32'd5, 64'd5, 3'd1);
    wait_req3("t6_req_seen");
    check("t6_wr_num", if3.commit_wr_num, 64'd5);
    load(64'd100);
    check("t6_req_dropped", 64'(if3.commit_wr_req), 64'd0);
    check("t6_commit3", commit3, 64'd100);
    check("t6_eng3", 64'(eng3), 64'd1);
    check("t6_commit5", commit5, 64'd100);
    check("t6_no_write", 64'(writes3), 64'(w3));
    wr_rdy = 1'b1;
    lpo = 64'd200;
    send(1'b1, 32'd5, 64'd101, 3'd1); wait_idle(1'b1, "t6_idle_a");
    check("t6_map_cleared", commit5, 64'd100);
    send(1'b1, 32'd5, 64'd101, 3'd3); wait_idle(1'b1, "t6_idle_b");
    check("t6_commit5_101", commit5, 64'd101);
    send(1'b0, 32'd5, 64'd101, 3'd1); wait_idle(1'b0, "t6_idle_c");
    check("t6_commit3_101", commit3, 64'd101);
    check("t6_write_num", last_wr3, 64'd101);

    // Load coinciding with a message in READY blocks the accept.
    @(negedge clk);
    load_val = 1'b1; load_num = 64'd101;
    m_view = 32'd6; m_op = 64'd102; m_idx = 3'd1; val3 = 1'b1;
    #1;
    check("coincide_rdy", 64'(if3.prep_ok_msg_rdy), 64'd0);
    @(negedge clk);
    load_val = 1'b0; val3 = 1'b0;
    #1;
    check("coincide_eng", 64'(eng3), 64'd1);
    check("coincide_commit", commit3, 64'd101);
    check("coincide_drop", 64'(drop3), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
